// File: rtl/adder_pkg.sv
// Shared state encoding and helpers for the bit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A new operation may only be accepted when no bits are in flight.
  function automatic logic accepts_start(state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell shared by the serial datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell, LSB first, WIDTH cycles per operation.
// Handshake: start is sampled only in IDLE/DONE; done pulses for one cycle with sum/cout/ovf valid.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-2:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_s, fa_c;
  logic [WIDTH-1:0]   shifted;

  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Partial result with the newest bit entering at the MSB.
  assign shifted = {fa_s, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accepts_start(state_q) && start) begin
          // Subtraction is a + ~b + 1, so invert b and fold the borrow into the carry.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        res_d   = shifted[WIDTH-1:1];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          sum_d   = shifted;
          cout_d  = fa_c;
          ovf_d   = fa_c ^ carry_q;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
